// File: rtl/disp_pkg.sv
// Shared state encoding, beat size and burst-length helper for the display line fetcher.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package disp_pkg;

    localparam int P_BEAT_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_REQ        = 2'd2,
        ST_WAIT_DATA  = 2'd3
    } fetch_state_t;

    // A programmed burst length of zero still moves one beat.
    function automatic logic [7:0] eff_burst_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Burst start address and beat count for the next burst of the line being fetched.
// Latency: combinational; the caller registers the result when it issues the request.
// Backpressure: none; outputs follow the inputs.
module burst_addr_gen #(
    parameter int P_VCNT       = 11,
    parameter int P_LBEAT      = 12,
    parameter int P_BEAT_BYTES = disp_pkg::P_BEAT_BYTES
) (
    input  logic [31:0]        base_addr,
    input  logic [15:0]        stride,
    input  logic [P_VCNT-1:0]  line_idx,
    input  logic [P_LBEAT-1:0] beat_off,
    input  logic [P_LBEAT-1:0] line_beats,
    input  logic [7:0]         burst_len,
    output logic [31:0]        addr,
    output logic [7:0]         len,
    output logic               last
);
    import disp_pkg::*;

    logic [7:0]         max_len;
    logic [P_LBEAT-1:0] remaining;
    logic [31:0]        line_addr;

    // Clip the burst to the beats left on the line; all address math wraps at 2^32.
    always_comb begin
        max_len   = eff_burst_len(burst_len);
        remaining = line_beats - beat_off;
        last      = (32'(remaining) <= 32'(max_len));
        len       = last ? 8'(remaining) : max_len;
        line_addr = base_addr + 32'(line_idx) * 32'(stride);
        addr      = line_addr + 32'(beat_off) * 32'(P_BEAT_BYTES);
    end

endmodule

// File: rtl/line_fetch_sched.sv
// Ping-pong line buffer fetch scheduler: issues memory bursts for each display line and tracks buffer occupancy/underrun.
// Latency: o_req rises 1 cycle after a line becomes pending; o_disp_buf updates 1 cycle after i_hclr.
// Backpressure: o_req/o_addr/o_len hold until i_ack; the next burst waits for i_rdone of the previous one.
module line_fetch_sched #(
    parameter int P_VCNT       = 11,
    parameter int P_BEAT_BYTES = disp_pkg::P_BEAT_BYTES,
    parameter int P_LBEAT      = 12
) (
    input  logic               i_clk,
    input  logic               i_xres,
    input  logic               i_enable,
    input  logic [31:0]        i_base_addr,
    input  logic [15:0]        i_stride,
    input  logic [P_LBEAT-1:0] i_line_beats,
    input  logic [7:0]         i_burst_len,
    input  logic [P_VCNT-1:0]  i_vlines,
    input  logic               i_fstart,
    input  logic               i_hclr,
    input  logic               i_vclr,
    output logic               o_req,
    input  logic               i_ack,
    output logic [31:0]        o_addr,
    output logic [7:0]         o_len,
    input  logic               i_rdone,
    output logic               o_wr_buf,
    output logic               o_discard,
    output logic               o_disp_buf,
    output logic               o_underrun,
    output logic               o_busy
);
    import disp_pkg::*;

    fetch_state_t       state_q, state_d;

    // Frame parameters latched at frame start.
    logic [31:0]        base_q;
    logic [15:0]        stride_q;
    logic [P_LBEAT-1:0] line_beats_q;
    logic [P_VCNT-1:0]  vlines_q;

    // Buffer bookkeeping.
    logic [1:0]         full_q, full_d;
    logic               fptr_q, dptr_q;
    logic [P_VCNT-1:0]  fetched_q;
    logic [P_LBEAT-1:0] beat_off_q;

    // Flags and the registered burst presented on the request port.
    logic               restart_q, discard_q, underrun_q;
    logic               last_q, wr_buf_q;
    logic [31:0]        addr_q;
    logic [7:0]         len_q;

    logic [31:0]        gen_addr;
    logic [7:0]         gen_len;
    logic               gen_last;

    logic               pending, ack_take, rdone_take, line_done;
    logic               release_buf, chk_idx, issue;

    burst_addr_gen #(
        .P_VCNT       (P_VCNT),
        .P_LBEAT      (P_LBEAT),
        .P_BEAT_BYTES (P_BEAT_BYTES)
    ) u_gen (
        .base_addr  (base_q),
        .stride     (stride_q),
        .line_idx   (fetched_q),
        .beat_off   (beat_off_q),
        .line_beats (line_beats_q),
        .burst_len  (i_burst_len),
        .addr       (gen_addr),
        .len        (gen_len),
        .last       (gen_last)
    );

    // Handshake qualification, pending-line test and next buffer-full vector.
    always_comb begin
        pending     = (fetched_q < vlines_q) && !full_q[fptr_q] && !restart_q
                      && (line_beats_q != '0);
        ack_take    = (state_q == ST_REQ) && i_ack;
        rdone_take  = (state_q == ST_WAIT_DATA) && i_rdone;
        // A discarded burst, or one completing as a new frame starts, fills nothing.
        line_done   = rdone_take && last_q && !restart_q && !i_fstart;
        release_buf = i_hclr && !i_vclr;
        chk_idx     = i_vclr ? 1'b0 : ~dptr_q;
        full_d      = full_q;
        if (release_buf) begin
            full_d[dptr_q] = 1'b0;
        end
        if (line_done) begin
            full_d[fptr_q] = 1'b1;
        end
    end

    // Next-state logic; a new burst is loaded whenever REQ is entered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (!i_enable)                 state_d = ST_IDLE;
                else if (pending && !i_fstart) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (i_ack)          state_d = ST_WAIT_DATA;
                else if (!i_enable) state_d = ST_IDLE;
                else if (i_fstart)  state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_DATA: begin
                if (i_rdone) begin
                    if (!i_enable)                         state_d = ST_IDLE;
                    else if (restart_q || i_fstart || last_q) state_d = ST_WAIT_FRAME;
                    else                                   state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        issue = (state_d == ST_REQ) && (state_q != ST_REQ);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_xres) begin
        if (!i_xres) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Frame parameters, buffer occupancy, fetch/display pointers and beat progress.
    always_ff @(posedge i_clk or negedge i_xres) begin
        if (!i_xres) begin
            base_q       <= '0;
            stride_q     <= '0;
            line_beats_q <= '0;
            vlines_q     <= '0;
            full_q       <= '0;
            fptr_q       <= 1'b0;
            dptr_q       <= 1'b0;
            fetched_q    <= '0;
            beat_off_q   <= '0;
        end else if (i_fstart) begin
            base_q       <= i_base_addr;
            stride_q     <= i_stride;
            line_beats_q <= i_line_beats;
            vlines_q     <= i_vlines;
            full_q       <= '0;
            fptr_q       <= 1'b0;
            dptr_q       <= 1'b0;
            fetched_q    <= '0;
            beat_off_q   <= '0;
        end else begin
            full_q <= full_d;
            if (ack_take) begin
                beat_off_q <= beat_off_q + P_LBEAT'(len_q);
            end
            if (line_done) begin
                fptr_q     <= ~fptr_q;
                fetched_q  <= fetched_q + P_VCNT'(1);
                beat_off_q <= '0;
            end
            if (i_hclr) begin
                dptr_q <= i_vclr ? 1'b0 : ~dptr_q;
            end
        end
    end

    // Capture the burst descriptor as the request is raised; it stays stable until acked.
    always_ff @(posedge i_clk or negedge i_xres) begin
        if (!i_xres) begin
            addr_q   <= '0;
            len_q    <= '0;
            last_q   <= 1'b0;
            wr_buf_q <= 1'b0;
        end else if (issue) begin
            addr_q   <= gen_addr;
            len_q    <= gen_len;
            last_q   <= gen_last;
            wr_buf_q <= fptr_q;
        end
    end

    // Restart/discard tracking for frame starts that land mid-burst, plus sticky underrun.
    always_ff @(posedge i_clk or negedge i_xres) begin
        if (!i_xres) begin
            restart_q  <= 1'b0;
            discard_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (i_fstart && (state_q == ST_REQ || state_q == ST_WAIT_DATA)) begin
                restart_q <= 1'b1;
            end else if (state_q == ST_IDLE || state_q == ST_WAIT_FRAME) begin
                restart_q <= 1'b0;
            end

            if (rdone_take) begin
                discard_q <= 1'b0;
            end else if (i_fstart && (state_q == ST_WAIT_DATA || ack_take)) begin
                discard_q <= 1'b1;
            end

            // The check uses registered occupancy, so a fill landing this cycle is too late.
            if (!i_enable) begin
                underrun_q <= 1'b0;
            end else if (i_hclr && !full_q[chk_idx]) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign o_req      = (state_q == ST_REQ);
    assign o_addr     = addr_q;
    assign o_len      = len_q;
    assign o_wr_buf   = wr_buf_q;
    assign o_discard  = discard_q;
    assign o_disp_buf = dptr_q;
    assign o_underrun = underrun_q;
    assign o_busy     = (state_q == ST_REQ) || (state_q == ST_WAIT_DATA);

endmodule

// File: tb/tb_line_fetch_sched.sv
// Self-checking bench for line_fetch_sched with a queue-based model of expected bursts.
// Latency: n/a.
// Backpressure: the bench acts as memory, acking and completing bursts with random delays.
module tb_line_fetch_sched;

    localparam int BEAT = 16;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        bit          buf_id;
        bit          last;
    } req_t;

    logic        i_clk;
    logic        i_xres;
    logic        i_enable;
    logic [31:0] i_base_addr;
    logic [15:0] i_stride;
    logic [11:0] i_line_beats;
    logic [7:0]  i_burst_len;
    logic [10:0] i_vlines;
    logic        i_fstart, i_hclr, i_vclr;
    logic        o_req, i_ack;
    logic [31:0] o_addr;
    logic [7:0]  o_len;
    logic        i_rdone;
    logic        o_wr_buf, o_discard, o_disp_buf, o_underrun, o_busy;

    int   vectors;
    int   miscompares;
    req_t exp_q[$];

    line_fetch_sched #(.P_VCNT(11), .P_BEAT_BYTES(16), .P_LBEAT(12)) dut (
        .i_clk        (i_clk),
        .i_xres       (i_xres),
        .i_enable     (i_enable),
        .i_base_addr  (i_base_addr),
        .i_stride     (i_stride),
        .i_line_beats (i_line_beats),
        .i_burst_len  (i_burst_len),
        .i_vlines     (i_vlines),
        .i_fstart     (i_fstart),
        .i_hclr       (i_hclr),
        .i_vclr       (i_vclr),
        .o_req        (o_req),
        .i_ack        (i_ack),
        .o_addr       (o_addr),
        .o_len        (o_len),
        .i_rdone      (i_rdone),
        .o_wr_buf     (o_wr_buf),
        .o_discard    (o_discard),
        .o_disp_buf   (o_disp_buf),
        .o_underrun   (o_underrun),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Every line split into bursts of at most max(burst_len,1) beats, in fetch order.
    function automatic void build_model(input logic [31:0] base, input logic [15:0] stride,
                                        input int lb, input int bl, input int vl);
        int   eff;
        req_t r;
        exp_q.delete();
        eff = (bl == 0) ? 1 : bl;
        for (int line = 0; line < vl; line++) begin
            for (int off = 0; off < lb; off += eff) begin
                r.addr   = base + 32'(line) * 32'(stride) + 32'(off) * 32'(BEAT);
                r.len    = 8'(((lb - off) < eff) ? (lb - off) : eff);
                r.buf_id = ((line % 2) == 1);
                r.last   = ((off + eff) >= lb);
                exp_q.push_back(r);
            end
        end
    endfunction

    task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                               input int lb, input int bl, input int vl);
        @(negedge i_clk);
        i_base_addr  = base;
        i_stride     = stride;
        i_line_beats = 12'(lb);
        i_burst_len  = 8'(bl);
        i_vlines     = 11'(vl);
        i_fstart     = 1'b1;
        @(negedge i_clk);
        i_fstart     = 1'b0;
        build_model(base, stride, lb, bl, vl);
    endtask

    task automatic wait_req_check(input req_t r, input bit do_ack);
        int t;
        t = 0;
        while (!o_req && t < 300) begin
            @(negedge i_clk);
            t++;
        end
        vectors++;
        if (o_req !== 1'b1) begin
            miscompares++;
            $display("FAIL req_timeout: o_req=%0b required 1 (addr 0x%08h)", o_req, r.addr);
            return;
        end
        vectors++;
        if (o_addr !== r.addr) begin
            miscompares++;
            $display("FAIL req_addr: got 0x%08h required 0x%08h", o_addr, r.addr);
        end
        vectors++;
        if (o_len !== r.len) begin
            miscompares++;
            $display("FAIL req_len: got %0d required %0d (addr 0x%08h)", o_len, r.len, r.addr);
        end
        vectors++;
        if (o_wr_buf !== r.buf_id) begin
            miscompares++;
            $display("FAIL req_wr_buf: got %0b required %0b (addr 0x%08h)", o_wr_buf, r.buf_id, r.addr);
        end
        vectors++;
        if (o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL req_busy: got %0b required 1", o_busy);
        end
        if (do_ack) begin
            i_ack = 1'b1;
            @(negedge i_clk);
            i_ack = 1'b0;
        end
    endtask

    task automatic finish_burst(input int dly, input bit exp_disc);
        repeat (dly) @(negedge i_clk);
        i_rdone = 1'b1;
        vectors++;
        if (o_discard !== exp_disc) begin
            miscompares++;
            $display("FAIL burst_discard: got %0b required %0b", o_discard, exp_disc);
        end
        @(negedge i_clk);
        i_rdone = 1'b0;
    endtask

    task automatic serve_one(input req_t r, input int dly);
        wait_req_check(r, 1'b1);
        finish_burst(dly, 1'b0);
    endtask

    task automatic pulse_hclr(input bit vclr, input bit exp_disp, input bit exp_ur);
        i_hclr = 1'b1;
        i_vclr = vclr;
        @(negedge i_clk);
        i_hclr = 1'b0;
        i_vclr = 1'b0;
        vectors++;
        if (o_disp_buf !== exp_disp) begin
            miscompares++;
            $display("FAIL disp_buf: got %0b required %0b", o_disp_buf, exp_disp);
        end
        vectors++;
        if (o_underrun !== exp_ur) begin
            miscompares++;
            $display("FAIL underrun_after_hclr: got %0b required %0b", o_underrun, exp_ur);
        end
    endtask

    task automatic check_idle(input int n, input string name);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge i_clk);
            if (o_req === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: o_req seen=%0b required 0 (addr 0x%08h)", name, seen, o_addr);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        vectors++; if (o_req !== 1'b0)      begin miscompares++; $display("FAIL rst_req: got %0b required 0", o_req); end
        vectors++; if (o_addr !== 32'd0)    begin miscompares++; $display("FAIL rst_addr: got 0x%08h required 0", o_addr); end
        vectors++; if (o_len !== 8'd0)      begin miscompares++; $display("FAIL rst_len: got %0d required 0", o_len); end
        vectors++; if (o_wr_buf !== 1'b0)   begin miscompares++; $display("FAIL rst_wr_buf: got %0b required 0", o_wr_buf); end
        vectors++; if (o_discard !== 1'b0)  begin miscompares++; $display("FAIL rst_discard: got %0b required 0", o_discard); end
        vectors++; if (o_disp_buf !== 1'b0) begin miscompares++; $display("FAIL rst_disp_buf: got %0b required 0", o_disp_buf); end
        vectors++; if (o_underrun !== 1'b0) begin miscompares++; $display("FAIL rst_underrun: got %0b required 0", o_underrun); end
        vectors++; if (o_busy !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: got %0b required 0", o_busy); end
        i_xres = 1'b1;
        @(negedge i_clk);
        i_enable = 1'b1;
        check_idle(10, "rst_no_req");
    endtask

    task automatic test_prefetch;
        start_frame(32'h0000_1000, 16'h0400, 64, 32, 4);
        for (int i = 0; i < 4; i++) serve_one(exp_q[i], i);
        check_idle(20, "prefetch_stall");
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL prefetch_busy: got %0b required 0", o_busy);
        end
    endtask

    task automatic test_steady;
        pulse_hclr(1'b1, 1'b0, 1'b0);
        pulse_hclr(1'b0, 1'b1, 1'b0);
        serve_one(exp_q[4], 1);
        serve_one(exp_q[5], 0);
        pulse_hclr(1'b0, 1'b0, 1'b0);
        serve_one(exp_q[6], 2);
        serve_one(exp_q[7], 1);
        pulse_hclr(1'b0, 1'b1, 1'b0);
        check_idle(15, "steady_stall");
    endtask

    // Display consumes a line whenever both buffers hold fetched lines.
    task automatic run_frame;
        int lines_done;
        int released;
        bit shown;
        lines_done = 0;
        released   = 0;
        shown      = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            serve_one(exp_q[i], int'($urandom_range(0, 3)));
            if (exp_q[i].last) lines_done++;
            if (lines_done - released == 2) begin
                if (!shown) begin
                    pulse_hclr(1'b1, 1'b0, 1'b0);
                    shown = 1'b1;
                end
                released++;
                pulse_hclr(1'b0, (released % 2) == 1, 1'b0);
            end
        end
        check_idle(20, "frame_end_stall");
        vectors++;
        if (o_underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_underrun: got %0b required 0", o_underrun);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 3; k++) begin
            start_frame($urandom(), 16'($urandom_range(0, 65535)),
                        int'($urandom_range(1, 40)), int'($urandom_range(0, 12)),
                        int'($urandom_range(1, 5)));
            run_frame();
        end
    endtask

    task automatic test_underrun;
        start_frame(32'h0001_0000, 16'h0040, 4, 8, 4);
        serve_one(exp_q[0], 0);
        serve_one(exp_q[1], 1);
        pulse_hclr(1'b1, 1'b0, 1'b0);
        pulse_hclr(1'b0, 1'b1, 1'b0);
        wait_req_check(exp_q[2], 1'b1);
        pulse_hclr(1'b0, 1'b0, 1'b1);
        finish_burst(1, 1'b0);
        repeat (5) @(negedge i_clk);
        vectors++;
        if (o_underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_sticky: got %0b required 1", o_underrun);
        end
        i_enable = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (o_underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_clear: got %0b required 0", o_underrun);
        end
        @(negedge i_clk);
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL disable_busy: got %0b required 0", o_busy);
        end
        start_frame(32'h0, 16'h0, 4, 8, 0);
        i_enable = 1'b1;
    endtask

    task automatic test_mid_fstart;
        start_frame(32'h0000_2000, 16'h0100, 4, 8, 4);
        wait_req_check(exp_q[0], 1'b1);
        start_frame(32'h0000_8000, 16'h0100, 4, 8, 4);
        finish_burst(1, 1'b1);
        serve_one(exp_q[0], 0);
        wait_req_check(exp_q[1], 1'b0);
        start_frame(32'h0003_0000, 16'h0200, 4, 8, 1);
        vectors++;
        if (o_req !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw_req: got %0b required 0", o_req);
        end
        serve_one(exp_q[0], 1);
        check_idle(15, "restart_stall");
    endtask

    task automatic test_edge;
        start_frame(32'h0004_0000, 16'h0080, 5, 0, 1);
        for (int i = 0; i < 5; i++) serve_one(exp_q[i], i % 2);
        check_idle(20, "edge_burst0_stall");
        start_frame(32'h0000_5000, 16'h0100, 8, 4, 0);
        check_idle(30, "edge_vlines0");
        start_frame(32'h0000_5000, 16'h0100, 0, 4, 3);
        check_idle(30, "edge_beats0");
    endtask

    task automatic test_reset_mid;
        start_frame(32'h0000_9000, 16'h0100, 4, 8, 2);
        wait_req_check(exp_q[0], 1'b1);
        i_xres = 1'b0;
        #1;
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_busy: got %0b required 0", o_busy);
        end
        vectors++;
        if (o_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_addr: got 0x%08h required 0", o_addr);
        end
        @(negedge i_clk);
        i_xres = 1'b1;
        check_idle(20, "after_midrst");
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        i_xres       = 1'b0;
        i_enable     = 1'b0;
        i_base_addr  = '0;
        i_stride     = '0;
        i_line_beats = '0;
        i_burst_len  = '0;
        i_vlines     = '0;
        i_fstart     = 1'b0;
        i_hclr       = 1'b0;
        i_vclr       = 1'b0;
        i_ack        = 1'b0;
        i_rdone      = 1'b0;

        test_reset();
        test_prefetch();
        test_steady();
        test_random();
        test_underrun();
        test_mid_fstart();
        test_edge();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_fetch_sched.md
LINE_FETCH_SCHED -- requirements
Module: line_fetch_sched

Interface
REQ-001 Parameters: P_VCNT=11 (line-count bit width); P_BEAT_BYTES=16 (bytes per memory beat); P_LBEAT=12 (beats-per-line bit width).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 i_clk  in  1  pixel clock.
REQ-004 i_xres  in  1  asynchronous reset, active-low.
REQ-005 i_enable  in  1  scheduler enable; low forces IDLE after any outstanding burst.
REQ-006 i_base_addr  in  32  frame base byte address, sampled at i_fstart.
REQ-007 i_stride  in  16  line pitch in bytes, sampled at i_fstart.
REQ-008 i_line_beats  in  P_LBEAT  beats per line, sampled at i_fstart.
REQ-009 i_burst_len  in  8  maximum beats per burst; 0 treated as 1.
REQ-010 i_vlines  in  P_VCNT  active lines per frame, sampled at i_fstart.
REQ-011 i_fstart  in  1  one-cycle pulse at vertical-blank start.
REQ-012 i_hclr  in  1  one-cycle pulse at the first DE of every line.
REQ-013 i_vclr  in  1  one-cycle pulse, coincident with i_hclr, marking the first line of a frame.
REQ-014 o_req / i_ack  out/in  1/1  burst request; o_req held until i_ack high in the same cycle.
REQ-015 o_addr  out  32  burst start byte address.
REQ-016 o_len  out  8  burst beat count (1..255).
REQ-017 i_rdone  in  1  pulse: last beat of the accepted burst written.
REQ-018 o_wr_buf  out  1  line buffer targeted by the current burst.
REQ-019 o_discard  out  1  high while the current burst's data must be dropped.
REQ-020 o_disp_buf  out  1  line buffer the display reads this line.
REQ-021 o_underrun  out  1  sticky underrun flag.
REQ-022 o_busy  out  1  high whenever the state is not IDLE or WAIT_FRAME.

Function
REQ-023 FSM states: IDLE, WAIT_FRAME, REQ, WAIT_DATA. Transitions:
- IDLE->WAIT_FRAME when i_enable is high.
- WAIT_FRAME->REQ when a line is pending.
- REQ->WAIT_DATA on i_ack.
- WAIT_DATA->REQ or WAIT_FRAME on i_rdone.
REQ-024 A line is pending when fetched_lines < vlines and full[fptr]==0 and the restart flag is clear.
REQ-025 i_fstart SHALL clear full[1:0], fptr, dptr and fetched_lines, and latch all sampled inputs.
REQ-026 If i_fstart arrives in REQ or WAIT_DATA, the block SHALL set the restart flag.
- The outstanding burst completes with o_discard high.
- The fetch then restarts at line 0.
- A REQ not yet acked is withdrawn the next cycle.
REQ-027 Line address = base + line*stride, computed modulo 2^32.
REQ-028 Burst address = line address + beat_offset*P_BEAT_BYTES.
REQ-029 o_len = min(remaining beats, max(i_burst_len,1)).
REQ-030 On i_rdone of the last burst of a line: full[fptr] is set, fptr toggles, fetched_lines increments.
REQ-031 i_hclr with i_vclr: no buffer release; dptr=0 is checked.
REQ-032 i_hclr without i_vclr: full[dptr] is cleared, dptr toggles, and the new dptr is checked.
REQ-033 Check: if registered full[dptr] is 0, o_underrun is set. A same-cycle i_rdone completion still counts as underrun.
REQ-034 Same-cycle release of one buffer and completion of the other SHALL both take effect.
REQ-035 o_underrun SHALL be cleared only by i_enable low or reset.
REQ-036 Buffer read latency: o_disp_buf is valid 1 cycle after i_hclr.
REQ-037 Request latency: o_req asserts 1 cycle after the pending condition becomes true.
REQ-038 vlines=0 or line_beats=0: no requests are issued.

Reset
REQ-039 Reset SHALL return the FSM to IDLE.
REQ-040 Reset values: o_req=0, o_addr=0, o_len=0, o_wr_buf=0, o_discard=0, o_disp_buf=0, o_underrun=0, o_busy=0.
REQ-041 Reset SHALL clear all counters and flags.
REQ-042 Reset mid-burst needs no memory-side completion.

Structure
REQ-043 The FSM state encoding and P_BEAT_BYTES SHALL live in shared package disp_pkg.
REQ-044 Burst address/length generation SHALL be one sub-module, burst_addr_gen.

Verification
REQ-045 Prefetch: base=0x1000, stride=0x400, line_beats=64, burst_len=32.
- Expected requests: (0x1000,32), (0x1200,32), (0x1400,32), (0x1600,32), then stall.
REQ-046 Steady state: i_hclr+i_vclr, then 3 i_hclr.
- Expected: o_disp_buf sequence 0,1,0,1; line 2 is fetched into buffer 0 after the first release; no underrun.
REQ-047 Underrun: delay i_rdone past i_hclr -> o_underrun=1 until i_enable low.
REQ-048 Mid-burst i_fstart:
- Expected: o_discard=1 for that burst, then a fresh request at the new base with o_wr_buf=0.
REQ-049 Edge sizes: burst_len=0, line_beats=5 -> five 1-beat requests; vlines=0 -> no o_req.
